sram_reader: RTL and testbench

- Playback-side counterpart of the bar writer. Reads stored music bars back out of the shared 16-bit SRAM.
- Each bar is four 16-bit words. They are reassembled into one 64-bit music word and presented to the sequencer/synth with a valid/ready handshake.
- Runs only in read mode (i_mode=0). Releases the SRAM control line whenever write mode is active.

---
 rtl/sram_music_pkg.sv | 23 ++
 rtl/sram_reader_if.sv | 29 ++
 rtl/sram_reader.sv | 120 ++++++++++++
 tb/tb_sram_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_music_pkg.sv
// Shared definitions for the music SRAM reader and writer: FSM states,
// bar layout constants and the bar-to-word-address mapping.
package sram_music_pkg;

  localparam int NUM_BARS      = 8;
  localparam int WORDS_PER_BAR = 4;
  localparam int BASE_ADDR     = 4;
  localparam int ADDR_W        = 20;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    READ,
    HOLD,
    DONE
  } state_t;

  // First word address of bar k; bars are packed back to back from BASE_ADDR.
  function automatic logic [ADDR_W-1:0] bar_base(input logic [2:0] k);
    return ADDR_W'(BASE_ADDR + int'(k) * WORDS_PER_BAR);
  endfunction

endpackage

// File: rtl/sram_reader_if.sv
// SRAM read bus plus the 64-bit music-word handshake towards the sequencer.
interface sram_reader_if;
  import sram_music_pkg::*;

  logic [15:0]       i_SRAM_DQ;
  logic [ADDR_W-1:0] o_addr;
  logic [63:0]       o_music_data;
  logic [2:0]        o_bar_idx;
  logic              o_valid;
  logic              i_ready;

  modport master (
    input  i_SRAM_DQ,
    input  i_ready,
    output o_addr,
    output o_music_data,
    output o_bar_idx,
    output o_valid
  );

  modport slave (
    output i_SRAM_DQ,
    output i_ready,
    input  o_addr,
    input  o_music_data,
    input  o_bar_idx,
    input  o_valid
  );
endinterface

// File: rtl/sram_reader.sv
// Scans the selected bar slots in SRAM, reads the four 16-bit words of each
// selected bar, and hands the assembled 64-bit bar to the consumer.
module sram_reader
  import sram_music_pkg::*;
(
  input  logic          i_bclk,
  input  logic          i_rst,
  input  logic          i_mode,
  input  logic          i_start,
  input  logic [7:0]    i_bar_sel,
  sram_reader_if.master bus,
  output wire           o_oe_n,
  output logic          o_done
);

  localparam logic [2:0] LAST_BAR = 3'(NUM_BARS - 1);

  state_t            state_q, state_d;
  logic [2:0]        bar_q, bar_d;
  logic [1:0]        word_q, word_d;
  logic [ADDR_W-1:0] addr_d;
  logic              valid_d;
  logic [2:0]        idx_d;
  logic              capture;
  logic              oe_drive;

  // Next-state and control updates; write mode overrides everything.
  always_comb begin
    state_d = state_q;
    bar_d   = bar_q;
    word_d  = word_q;
    addr_d  = bus.o_addr;
    valid_d = bus.o_valid;
    idx_d   = bus.o_bar_idx;
    capture = 1'b0;
    if (i_mode) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d = SCAN;
            bar_d   = 3'd0;
          end
        end
        SCAN: begin
          if (i_bar_sel[bar_q]) begin
            state_d = READ;
            addr_d  = bar_base(bar_q);
            word_d  = 2'd0;
          end else if (bar_q == LAST_BAR) begin
            state_d = DONE;
          end else begin
            bar_d = bar_q + 3'd1;
          end
        end
        READ: begin
          capture = 1'b1;
          if (word_q == 2'd3) begin
            state_d = HOLD;
            valid_d = 1'b1;
            idx_d   = bar_q;
          end else begin
            addr_d = bus.o_addr + ADDR_W'(1);
            word_d = word_q + 2'd1;
          end
        end
        HOLD: begin
          if (bus.i_ready) begin
            valid_d = 1'b0;
            if (bar_q == LAST_BAR) begin
              state_d = DONE;
            end else begin
              bar_d   = bar_q + 3'd1;
              state_d = SCAN;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters, address and handshake registers.
  always_ff @(posedge i_bclk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= IDLE;
      bar_q         <= 3'd0;
      word_q        <= 2'd0;
      bus.o_addr    <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_bar_idx <= 3'd0;
    end else begin
      state_q       <= state_d;
      bar_q         <= bar_d;
      word_q        <= word_d;
      bus.o_addr    <= addr_d;
      bus.o_valid   <= valid_d;
      bus.o_bar_idx <= idx_d;
    end
  end

  // Lane assembly: word n of the bar lands in bits [16n+15:16n].
  always_ff @(posedge i_bclk or negedge i_rst) begin
    if (!i_rst) begin
      bus.o_music_data <= '0;
    end else if (capture) begin
      bus.o_music_data[{word_q, 4'b0000} +: 16] <= bus.i_SRAM_DQ;
    end
  end

  // Output enable is gated by i_mode directly so the SRAM is released in the
  // same cycle write mode appears, not one edge later.
  assign oe_drive = (state_q == READ) && !i_mode;
  assign o_oe_n   = oe_drive ? 1'b0 : 1'bz;
  assign o_done   = (state_q == DONE);

endmodule

// File: tb/tb_sram_reader.sv
// Bench for sram_reader: an SRAM array model plus a cycle-level reference
// schedule derived from the scan rules (1 cycle per bar tested, 4 per read,
// stall + 1 per handshake).
module tb_sram_reader;
  import sram_music_pkg::*;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_mode;
  logic       i_start;
  logic [7:0] i_bar_sel;
  wire        oe_n;
  logic       done;
  int         tests = 0;
  int         fails = 0;
  logic [15:0] mem [64];

  always #5 clk = ~clk;

  sram_reader_if bus ();

  pullup (oe_n);

  assign bus.i_SRAM_DQ = mem[bus.o_addr[5:0]];

  sram_reader dut (
    .i_bclk    (clk),
    .i_rst     (i_rst),
    .i_mode    (i_mode),
    .i_start   (i_start),
    .i_bar_sel (i_bar_sel),
    .bus       (bus.master),
    .o_oe_n    (oe_n),
    .o_done    (done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_mem_random();
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (bus.o_addr !== 20'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", bus.o_addr); end
    tests++; if (bus.o_music_data !== 64'd0) begin fails++; $display("FAIL reset_data: got %h expected 0", bus.o_music_data); end
    tests++; if (bus.o_bar_idx !== 3'd0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", bus.o_bar_idx); end
    tests++; if (oe_n === 1'b0) begin fails++; $display("FAIL reset_oe: got %b expected released", oe_n); end
    i_rst = 1'b1;
    @(negedge clk);
  endtask

  // One complete scan, compared against the reference schedule.
  task automatic run_scan(input logic [7:0] sel, input int stall, input bit poke, input string name);
    int          exp_rise[$];
    logic [2:0]  exp_idx[$];
    logic [63:0] exp_data[$];
    logic [19:0] exp_addr[$];
    int          got_rise[$];
    logic [2:0]  got_idx[$];
    logic [63:0] got_data[$];
    logic [19:0] got_addr[$];
    int          exp_done, got_done, done_cnt, held, t, base;
    bit          unstable;
    logic [63:0] hold_data;
    logic [2:0]  hold_idx;

    t = 0;
    for (int k = 0; k < 8; k++) begin
      t++;
      if (sel[k]) begin
        base = 4 + 4 * k;
        for (int w = 0; w < 4; w++) exp_addr.push_back(20'(base + w));
        t += 4;
        exp_rise.push_back(t);
        exp_idx.push_back(3'(k));
        exp_data.push_back({mem[base+3], mem[base+2], mem[base+1], mem[base]});
        t += stall + 1;
      end
    end
    exp_done = t;

    i_bar_sel = sel;
    bus.i_ready = 1'b0;
    held = 0; got_done = -1; done_cnt = 0; unstable = 1'b0;
    hold_data = '0; hold_idx = '0;
    @(negedge clk); i_start = 1'b1;
    @(posedge clk);
    @(negedge clk); i_start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      @(negedge clk);
      i_start = poke && (n == 3);
      if (oe_n === 1'b0) got_addr.push_back(bus.o_addr);
      if (bus.o_valid === 1'b1) begin
        if (held == 0) begin
          got_rise.push_back(n);
          got_idx.push_back(bus.o_bar_idx);
          got_data.push_back(bus.o_music_data);
          hold_data = bus.o_music_data;
          hold_idx  = bus.o_bar_idx;
        end else if (bus.o_music_data !== hold_data || bus.o_bar_idx !== hold_idx) begin
          unstable = 1'b1;
        end
        held++;
        bus.i_ready = (held > stall);
      end else begin
        held = 0;
        bus.i_ready = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (got_done < 0) got_done = n;
      end
      if (got_done >= 0 && n >= got_done + 16) break;
    end
    i_start = 1'b0;
    bus.i_ready = 1'b0;

    tests++; if (got_rise.size() != exp_rise.size()) begin fails++; $display("FAIL %s beats: got %0d expected %0d", name, got_rise.size(), exp_rise.size()); end
    for (int i = 0; i < exp_rise.size() && i < got_rise.size(); i++) begin
      tests++; if (got_rise[i] != exp_rise[i]) begin fails++; $display("FAIL %s valid_edge[%0d]: got %0d expected %0d", name, i, got_rise[i], exp_rise[i]); end
      tests++; if (got_idx[i] !== exp_idx[i]) begin fails++; $display("FAIL %s bar_idx[%0d]: got %0d expected %0d", name, i, got_idx[i], exp_idx[i]); end
      tests++; if (got_data[i] !== exp_data[i]) begin fails++; $display("FAIL %s data[%0d]: got %h expected %h", name, i, got_data[i], exp_data[i]); end
    end
    tests++; if (got_done != exp_done) begin fails++; $display("FAIL %s done_edge: got %0d expected %0d", name, got_done, exp_done); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL %s done_count: got %0d expected 1", name, done_cnt); end
    tests++; if (got_addr.size() != exp_addr.size()) begin fails++; $display("FAIL %s read_cycles: got %0d expected %0d", name, got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      if (got_addr[i] !== exp_addr[i]) begin
        tests++; fails++;
        $display("FAIL %s addr[%0d]: got %0d expected %0d", name, i, got_addr[i], exp_addr[i]);
        break;
      end
    end
    if (stall > 0) begin
      tests++; if (unstable) begin fails++; $display("FAIL %s hold_stable: got changed expected stable", name); end
    end
  endtask

  task automatic test_single_bar();
    mem[4] = 16'h1111; mem[5] = 16'h2222; mem[6] = 16'h3333; mem[7] = 16'h4444;
    run_scan(8'h01, 0, 1'b0, "single_bar");
  endtask

  task automatic test_two_bars();
    fill_mem_random();
    run_scan(8'hA0, 0, 1'b0, "two_bars");
  endtask

  task automatic test_no_bars();
    run_scan(8'h00, 0, 1'b0, "no_bars");
  endtask

  task automatic test_stall();
    fill_mem_random();
    run_scan(8'h01, 10, 1'b0, "stall");
  endtask

  task automatic test_busy_start();
    fill_mem_random();
    run_scan(8'h13, 1, 1'b1, "busy_start");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      fill_mem_random();
      run_scan(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $sformatf("random%0d", r));
    end
  endtask

  task automatic test_mode_abort();
    int bad_valid, bad_done, bad_oe;
    mem[4] = 16'hA1A1; mem[5] = 16'hB2B2; mem[6] = 16'hC3C3; mem[7] = 16'hD4D4;
    i_bar_sel = 8'h01;
    bus.i_ready = 1'b1;
    @(negedge clk); i_start = 1'b1;
    @(posedge clk);
    @(negedge clk); i_start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    tests++; if (oe_n !== 1'b0) begin fails++; $display("FAIL abort_in_read: got oe_n %b expected 0", oe_n); end
    tests++; if (bus.o_addr !== 20'd6) begin fails++; $display("FAIL abort_word2_addr: got %0d expected 6", bus.o_addr); end
    i_mode = 1'b1;
    #1;
    tests++; if (oe_n === 1'b0) begin fails++; $display("FAIL abort_oe_now: got %b expected released", oe_n); end
    @(posedge clk); @(negedge clk);
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b expected 0", bus.o_valid); end
    tests++; if (oe_n === 1'b0) begin fails++; $display("FAIL abort_oe: got %b expected released", oe_n); end
    bad_valid = 0; bad_done = 0; bad_oe = 0;
    if (done === 1'b1) bad_done++;
    i_start = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); @(negedge clk);
      i_start = 1'b0;
      if (bus.o_valid === 1'b1) bad_valid++;
      if (done === 1'b1) bad_done++;
      if (oe_n === 1'b0) bad_oe++;
    end
    tests++; if (bad_valid != 0) begin fails++; $display("FAIL mode_idle_valid: got %0d cycles expected 0", bad_valid); end
    tests++; if (bad_done != 0) begin fails++; $display("FAIL mode_idle_done: got %0d cycles expected 0", bad_done); end
    tests++; if (bad_oe != 0) begin fails++; $display("FAIL mode_idle_oe: got %0d cycles expected 0", bad_oe); end
    i_mode = 1'b0;
    bus.i_ready = 1'b0;
    @(negedge clk);
    run_scan(8'h01, 0, 1'b0, "reread");
  endtask

  task automatic test_reset_mid();
    int waited, extra;
    logic [2:0] idx_before;
    fill_mem_random();
    i_bar_sel = 8'h09;
    bus.i_ready = 1'b0;
    @(negedge clk); i_start = 1'b1;
    @(posedge clk);
    @(negedge clk); i_start = 1'b0;
    waited = 0;
    while (bus.o_valid !== 1'b1 && waited < 30) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL rstmid_reach_hold: got valid %b expected 1", bus.o_valid); end
    idx_before = bus.o_bar_idx;
    i_start = 1'b1;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    tests++; if (bus.o_valid !== 1'b1 || bus.o_bar_idx !== idx_before) begin fails++; $display("FAIL busy_start_hold: got valid %b idx %0d expected 1 idx %0d", bus.o_valid, bus.o_bar_idx, idx_before); end
    #2 i_rst = 1'b0;
    #1;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b expected 0", bus.o_valid); end
    tests++; if (bus.o_addr !== 20'd0) begin fails++; $display("FAIL rstmid_addr: got %0d expected 0", bus.o_addr); end
    tests++; if (bus.o_music_data !== 64'd0) begin fails++; $display("FAIL rstmid_data: got %h expected 0", bus.o_music_data); end
    tests++; if (oe_n === 1'b0) begin fails++; $display("FAIL rstmid_oe: got %b expected released", oe_n); end
    @(negedge clk); i_rst = 1'b1;
    bus.i_ready = 1'b1;
    extra = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); @(negedge clk);
      if (bus.o_valid === 1'b1 || done === 1'b1 || oe_n === 1'b0) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL rstmid_idle: got %0d active cycles expected 0", extra); end
    bus.i_ready = 1'b0;
  endtask

  initial begin
    i_rst = 1'b0;
    i_mode = 1'b0;
    i_start = 1'b0;
    i_bar_sel = 8'h00;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    test_reset();
    test_single_bar();
    test_two_bars();
    test_no_bars();
    test_stall();
    test_busy_start();
    test_mode_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
